mest_pro_fetch_unit: RTL

Instruction fetch stage of the MEST Pro core. Holds the program counter (PC), issues instruction-memory reads when the core controller is in its FETCH state, and latches the returned word into the instruction register (IR) for decode. It also advances or redirects the PC during EXECUTE and generates the end-of-code flag the controller uses to return to IDLE.

---
 rtl/mest_pro_pkg.sv | 15 +
 rtl/mest_pro_fetch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/mest_pro_pkg.sv
// Shared MEST Pro definitions: fetch FSM states, default field widths and the
// halt opcode shared between the fetch unit and the decoder.
package mest_pro_pkg;

  localparam int         ADDR_W_DEF   = 8;
  localparam int         INSTR_W_DEF  = 16;
  localparam int         OPC_W_DEF    = 4;
  localparam logic [3:0] HALT_OPC_DEF = 4'hF;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/mest_pro_fetch_unit.sv
// MEST Pro instruction fetch stage: owns the PC, issues instruction reads,
// latches the instruction register and raises end-of-code / protocol error.
module mest_pro_fetch_unit
  import mest_pro_pkg::*;
#(
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 INSTR_W  = INSTR_W_DEF,
  parameter int                 OPC_W    = OPC_W_DEF,
  parameter logic [OPC_W-1:0]   HALT_OPC = OPC_W'(HALT_OPC_DEF)
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_start_addr,
  input  logic               i_fetch,
  input  logic               i_execute,
  input  logic               i_branch_valid,
  input  logic [ADDR_W-1:0]  i_branch_target,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic               i_mem_ack,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic               o_busy,
  output logic               o_end_of_code,
  output logic               o_err
);

  localparam logic [0:0] S_IDLE = FETCH_IDLE;
  localparam logic [0:0] S_WAIT = FETCH_WAIT;

  logic [0:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic               instr_valid;
  logic               end_of_code;
  logic               err;

  logic               in_idle;
  logic               in_wait;
  logic               new_fetch;
  logic               ir_load;
  logic               start_accept;
  logic               rdata_is_halt;
  logic               pc_at_top;

  assign in_idle       = (state == S_IDLE);
  assign in_wait       = (state == S_WAIT);
  assign new_fetch     = in_idle && i_fetch;
  assign ir_load       = (new_fetch || in_wait) && i_mem_ack;
  assign start_accept  = in_idle && i_start;
  assign rdata_is_halt = (i_mem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPC);
  assign pc_at_top     = (pc == {ADDR_W{1'b1}});

  // Request is gated by reset so an in-flight read drops without a clock edge.
  assign o_mem_req     = !i_reset && (new_fetch || in_wait);
  assign o_mem_addr    = pc;
  assign o_busy        = in_wait;
  assign o_instr       = ir;
  assign o_instr_valid = instr_valid;
  assign o_end_of_code = end_of_code;
  assign o_err         = err;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_fetch && !i_mem_ack) state <= S_WAIT;
        S_WAIT:  if (i_mem_ack)             state <= S_IDLE;
        default:                            state <= S_IDLE;
      endcase
    end
  end

  // An accepted start is applied last so it overrides same-cycle updates.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      pc          <= '0;
      ir          <= '0;
      instr_valid <= 1'b0;
      end_of_code <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (ir_load) begin
        ir          <= i_mem_rdata;
        instr_valid <= 1'b1;
        if (rdata_is_halt) end_of_code <= 1'b1;
      end else if (new_fetch) begin
        instr_valid <= 1'b0;
      end

      if (in_wait && (i_fetch || i_start)) err <= 1'b1;

      // Falling off the top of memory ends the program instead of wrapping.
      if (i_execute && !end_of_code) begin
        if (i_branch_valid)  pc          <= i_branch_target;
        else if (pc_at_top)  end_of_code <= 1'b1;
        else                 pc          <= pc + ADDR_W'(1);
      end

      if (start_accept) begin
        pc          <= i_start_addr;
        instr_valid <= 1'b0;
        end_of_code <= 1'b0;
        err         <= 1'b0;
      end
    end
  end

endmodule
